// File: rtl/fp32_pow_seq.sv
// fp32_pow_seq: drives an external FP32 multiplier to produce x^1..x^n.
// Each power is emitted as an indexed one-cycle strobe. A multiply that does
// not complete within TIMEOUT cycles aborts the request with an error.
//
// Multiplier handshake (initiator side):
//   mul_valid_o pulses for exactly one cycle per request. mul_a_o and mul_b_o
//   are loaded as the ISSUE state is entered and are held until the next
//   request. At most one request is outstanding. mul_done_i is accepted only
//   in WAIT and is ignored in every other state.
module fp32_pow_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int N_MAX      = 16,
  parameter int IDX_W      = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [IDX_W-1:0]      n_i,
  output logic                  busy_o,
  output logic                  term_valid_o,
  output logic [DATA_WIDTH-1:0] term_o,
  output logic [IDX_W-1:0]      term_idx_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mul_valid_o,
  output logic [DATA_WIDTH-1:0] mul_a_o,
  output logic [DATA_WIDTH-1:0] mul_b_o,
  input  logic [DATA_WIDTH-1:0] mul_result_i,
  input  logic                  mul_done_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] N_MAX_V   = IDX_W'(N_MAX);
  localparam logic [TW-1:0]    TO_LAST_V = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EMIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]      n_q, n_d;
  logic [IDX_W-1:0]      k_q, k_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] term_q, term_d;
  logic [IDX_W-1:0]      term_idx_q, term_idx_d;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0] mul_b_q, mul_b_d;
  logic [IDX_W-1:0]      n_clamp;

  // Requested term count saturated at N_MAX.
  assign n_clamp = (n_i > N_MAX_V) ? N_MAX_V : n_i;

  // Next-state and datapath update; the held output registers load only as the
  // state that strobes them is entered, so they are stable otherwise.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    n_d        = n_q;
    k_d        = k_q;
    timer_d    = timer_q;
    term_d     = term_q;
    term_idx_d = term_idx_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d   = x_i;
          n_d   = n_clamp;
          k_d   = IDX_W'(1);
          acc_d = x_i;
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_EMIT;
            term_d     = x_i;
            term_idx_d = IDX_W'(1);
          end
        end
      end
      S_EMIT: begin
        if (k_q == n_q) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + IDX_W'(1);
          mul_a_d = acc_q;
          mul_b_d = x_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done_i) begin
          acc_d      = mul_result_i;
          term_d     = mul_result_i;
          term_idx_d = k_q;
          state_d    = S_EMIT;
        end else if (timer_q == TO_LAST_V) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      acc_q      <= '0;
      n_q        <= '0;
      k_q        <= '0;
      timer_q    <= '0;
      term_q     <= '0;
      term_idx_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      k_q        <= k_d;
      timer_q    <= timer_d;
      term_q     <= term_d;
      term_idx_q <= term_idx_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
    end
  end

  // Moore output decode from registered state and data.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    term_valid_o = (state_q == S_EMIT);
    done_o       = (state_q == S_DONE) || (state_q == S_ERR);
    err_o        = (state_q == S_ERR);
    mul_valid_o  = (state_q == S_ISSUE);
    term_o       = term_q;
    term_idx_o   = term_idx_q;
    mul_a_o      = mul_a_q;
    mul_b_o      = mul_b_q;
  end

endmodule

// File: tb/tb_fp32_pow_seq.sv
// Bench for fp32_pow_seq: a behavioural multiplier responder, a monitor feeding
// a term scoreboard, and directed plus randomized requests.
module tb_fp32_pow_seq;

  localparam int DW = 32;
  localparam int NM = 16;
  localparam int IW = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] x_i = '0;
  logic [IW-1:0] n_i = '0;
  logic          busy_o, term_valid_o, done_o, err_o, mul_valid_o;
  logic [DW-1:0] term_o, mul_a_o, mul_b_o;
  logic [IW-1:0] term_idx_o;
  logic [DW-1:0] mul_result_i = '0;
  logic          mul_done_i = 1'b0;

  // Clock / reset block
  always #5 clk = ~clk;

  fp32_pow_seq #(.DATA_WIDTH(DW), .N_MAX(NM), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .x_i(x_i), .n_i(n_i),
    .busy_o(busy_o), .term_valid_o(term_valid_o), .term_o(term_o),
    .term_idx_o(term_idx_o), .done_o(done_o), .err_o(err_o),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Scoreboard: expected {idx, term} in emission order.
  logic [IW+DW-1:0] exp_q[$];

  int            mul_cnt, done_cnt, err_cnt, term_cnt, extra, stable_err;
  int            cyc_mul, cyc_done, cyc_last_term;
  logic [DW-1:0] pend_a, pend_b, cur_x, last_term;
  bit            pending;
  int            resp_lat = 1;
  bit            resp_never = 1'b0;
  int            cd = 0;
  logic [DW-1:0] resp_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in multiplier: exact for power-of-two operands, a fixed bit hash otherwise.
  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    int e;
    logic [15:0] lo;
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (a[22:0] == 23'd0 && b[22:0] == 23'd0 && a[30:23] != 8'd0 &&
        b[30:23] != 8'd0 && e >= 1 && e <= 254)
      return {a[31] ^ b[31], e[7:0], 23'd0};
    lo = a[31:16] + b[15:0];
    return {a[15:0] ^ b[31:16], lo};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder and monitor, evaluated mid-cycle.
  initial forever begin
    logic [IW+DW-1:0] e;
    @(negedge clk);
    if (mul_done_i) mul_done_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mul_done_i   = 1'b1;
        mul_result_i = resp_val;
      end
    end
    if (pending && (mul_a_o !== pend_a || mul_b_o !== pend_b)) stable_err++;
    if (mul_valid_o) begin
      mul_cnt++;
      cyc_mul = cyc;
      pending = 1'b1;
      pend_a  = mul_a_o;
      pend_b  = mul_b_o;
      chk("mul_b_is_x", mul_b_o, cur_x);
      chk("mul_a_is_last_term", mul_a_o, last_term);
      if (!resp_never) begin
        cd       = resp_lat;
        resp_val = mul_ref(mul_a_o, mul_b_o);
      end
    end
    if (term_valid_o) begin
      term_cnt++;
      cyc_last_term = cyc;
      pending       = 1'b0;
      last_term     = term_o;
      if (exp_q.size() == 0) extra++;
      else begin
        e = exp_q.pop_front();
        chk("term_val", term_o, e[DW-1:0]);
        chk("term_idx", {27'd0, term_idx_o}, {27'd0, e[IW+DW-1:DW]});
      end
    end
    if (done_o) begin
      done_cnt++;
      cyc_done = cyc;
      pending  = 1'b0;
      if (err_o) err_cnt++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    mul_cnt = 0; done_cnt = 0; err_cnt = 0; term_cnt = 0; extra = 0;
    stable_err = 0; pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {26'd0, busy_o, term_valid_o, done_o, err_o, mul_valid_o, mul_done_i & 1'b0},
        32'd0);
    chk({tag, "_term"}, term_o, 32'd0);
    chk({tag, "_idx"}, {27'd0, term_idx_o}, 32'd0);
    chk({tag, "_mul_a"}, mul_a_o, 32'd0);
    chk({tag, "_mul_b"}, mul_b_o, 32'd0);
  endtask

  task automatic run_req(input logic [31:0] x, input int n, input int lat,
                         input bit never, input bit spam);
    int nn, nexp;
    logic [31:0] acc;
    clear_counts();
    resp_lat   = lat;
    resp_never = never;
    cur_x      = x;
    nn   = (n > NM) ? NM : n;
    nexp = never ? ((nn > 0) ? 1 : 0) : nn;
    acc  = x;
    for (int k = 1; k <= nexp; k++) begin
      exp_q.push_back({IW'(k), acc});
      acc = mul_ref(acc, x);
    end
    tick();
    start_i = 1'b1; x_i = x; n_i = IW'(n);
    tick();
    start_i = 1'b0;
    chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
    if (nn > 0) chk("term1_next_cycle", {31'd0, term_valid_o}, 32'd1);
    else begin
      chk("n0_done", {31'd0, done_o}, 32'd1);
      chk("n0_err", {31'd0, err_o}, 32'd0);
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (spam && busy_o) start_i = 1'($urandom_range(0, 1));
      tick();
    end
    start_i = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("err_count", err_cnt, never ? 1 : 0);
    chk("mul_pulses", mul_cnt, never ? ((nn > 1) ? 1 : 0) : ((nn > 0) ? nn - 1 : 0));
    chk("term_count", term_cnt, nexp);
    chk("terms_left", exp_q.size(), 0);
    chk("extra_terms", extra, 0);
    chk("ab_stable", stable_err, 0);
    if (never) chk("timeout_latency", cyc_done - cyc_mul, TO + 1);
    else if (nn > 0) chk("done_after_emit", cyc_done - cyc_last_term, 1);
    tick();
    chk("busy_low_after", {31'd0, busy_o}, 32'd0);
    repeat (4) tick();
    chk("single_done", done_cnt, 1);
  endtask

  // Main sequence and final report
  initial begin
    logic [31:0] rx;
    clear_counts();
    rstn_i = 1'b0;
    repeat (3) tick();
    check_reset_outs("reset");
    rstn_i = 1'b1;
    tick();

    run_req(32'h4000_0000, 4, 1, 1'b0, 1'b0);
    run_req(32'h3f80_0000, 1, 2, 1'b0, 1'b0);
    run_req(32'h1234_5678, 0, 1, 1'b0, 1'b0);
    run_req(32'h3e2a_aaab, 3, 1, 1'b1, 1'b0);
    run_req(32'h3f00_0000, 20, 2, 1'b0, 1'b1);

    // Reset during WAIT with a late multiplier completion.
    clear_counts();
    resp_lat = 6; resp_never = 1'b0; cur_x = 32'h4040_0000;
    exp_q.push_back({IW'(1), 32'h4040_0000});
    tick();
    start_i = 1'b1; x_i = 32'h4040_0000; n_i = IW'(5);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 50 && mul_cnt == 0; i++) tick();
    chk("rst_test_issue", mul_cnt, 1);
    repeat (2) tick();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    check_reset_outs("mid_reset");
    repeat (10) tick();
    chk("late_done_no_done", done_cnt, 0);
    chk("late_done_no_term", term_cnt, 1);
    chk("rst_extra", extra, 0);
    run_req(32'h4040_0000, 5, 3, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1)
        rx = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'd0};
      else
        rx = $urandom;
      run_req(rx, $urandom_range(0, 20), $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
